// File: rtl/egress_scheduler_if.sv
// Processor-side and link-side handshake bundle for egress_scheduler.
// The DUT attaches through the slave modport; the requester/link model attaches through master.
interface egress_scheduler_if #(
  parameter int DATA_SIZE  = 8,
  parameter int TIMER_SIZE = 32
);
  logic [DATA_SIZE-1:0]  data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic                  last_in;
  logic [TIMER_SIZE-1:0] clock_cycles;
  logic                  clock_cycles_valid;
  logic                  clock_cycles_ready;
  logic [DATA_SIZE-1:0]  data_out;
  logic                  valid_out;
  logic                  ready_out;
  logic                  last_out;
  logic                  busy;

  modport slave (
    input  data_in, valid_in, last_in, clock_cycles, clock_cycles_valid, ready_out,
    output ready_in, clock_cycles_ready, data_out, valid_out, last_out, busy
  );

  modport master (
    output data_in, valid_in, last_in, clock_cycles, clock_cycles_valid, ready_out,
    input  ready_in, clock_cycles_ready, data_out, valid_out, last_out, busy
  );
endinterface

// File: rtl/egress_scheduler.sv
// Frames one processor result plus its cycle count onto a shared byte link:
// header byte, pass-through result beats, then the count MSB-first with last on the final beat.
module egress_scheduler #(
  parameter int                   DATA_SIZE   = 8,
  parameter int                   TIMER_SIZE  = 32,
  parameter logic [DATA_SIZE-1:0] HEADER_BYTE = 8'hA5
) (
  input logic               clock,
  input logic               reset,
  egress_scheduler_if.slave bus
);
  localparam int N     = TIMER_SIZE / DATA_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] HEADER     = 3'd1;
  localparam logic [2:0] STREAM     = 3'd2;
  localparam logic [2:0] COUNT_WAIT = 3'd3;
  localparam logic [2:0] COUNT_SEND = 3'd4;

  logic [2:0]            r_state;
  logic [IDX_W-1:0]      r_index;
  logic [TIMER_SIZE-1:0] r_shift;
  logic                  w_last_beat;

  assign w_last_beat = (r_index == LAST_IDX);

  always_comb begin
    bus.data_out           = '0;
    bus.valid_out          = 1'b0;
    bus.last_out           = 1'b0;
    bus.ready_in           = 1'b0;
    bus.clock_cycles_ready = 1'b0;
    bus.busy               = (r_state != IDLE);
    case (r_state)
      HEADER: begin
        bus.data_out  = HEADER_BYTE;
        bus.valid_out = 1'b1;
      end
      // Zero-latency pass-through; last_in is deliberately not forwarded.
      STREAM: begin
        bus.data_out  = bus.data_in;
        bus.valid_out = bus.valid_in;
        bus.ready_in  = bus.ready_out;
      end
      COUNT_WAIT: begin
        bus.clock_cycles_ready = 1'b1;
      end
      COUNT_SEND: begin
        bus.data_out  = r_shift[TIMER_SIZE-1 -: DATA_SIZE];
        bus.valid_out = 1'b1;
        bus.last_out  = w_last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.valid_in) r_state <= HEADER;
        end
        HEADER: begin
          if (bus.ready_out) r_state <= STREAM;
        end
        STREAM: begin
          if (bus.valid_in && bus.ready_out && bus.last_in) r_state <= COUNT_WAIT;
        end
        COUNT_WAIT: begin
          if (bus.clock_cycles_valid) begin
            r_shift <= bus.clock_cycles;
            r_index <= '0;
            r_state <= COUNT_SEND;
          end
        end
        COUNT_SEND: begin
          if (bus.ready_out) begin
            r_shift <= r_shift << DATA_SIZE;
            if (w_last_beat) begin
              r_state <= IDLE;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_egress_scheduler.sv
// Self-checking bench for egress_scheduler: IDLE/HEADER vector table, directed frames and random frames
// compared against an expected byte list built from the framing rules.
module tb_egress_scheduler;
  localparam int DW = 8;
  localparam int TW = 32;
  localparam int N  = TW / DW;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic       rst;
    logic       vi;
    logic       ccv;
    logic       ro;
    logic       vo;
    logic [7:0] dout;
    logic       bsy;
    logic       ccr;
    logic       rin;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  egress_scheduler_if #(.DATA_SIZE(DW), .TIMER_SIZE(TW)) bus ();

  egress_scheduler #(
    .DATA_SIZE  (DW),
    .TIMER_SIZE (TW),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.valid_in           = 1'b0;
    bus.data_in            = 8'h00;
    bus.last_in            = 1'b0;
    bus.clock_cycles_valid = 1'b0;
    bus.clock_cycles       = 32'h0;
    bus.ready_out          = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},      bus.busy, 0);
    check({tag, ".valid_out"}, bus.valid_out, 0);
    check({tag, ".data_out"},  bus.data_out, 0);
    check({tag, ".last_out"},  bus.last_out, 0);
    check({tag, ".ready_in"},  bus.ready_in, 0);
    check({tag, ".cc_ready"},  bus.clock_cycles_ready, 0);
  endtask

  // rmode: 0 = ready always high, 1 = repeating 1,0,0,1, 2 = random.
  // abort >= 0: assert reset once that many count bytes have been accepted.
  task automatic run_frame(input byte_q_t pl, input logic [31:0] cnt, input int rmode,
                           input int delay, input int abort, input string tag);
    byte_q_t    exp_q;
    byte_q_t    got_d;
    logic       got_l[$];
    int         p = 0;
    int         wait_cnt = 0;
    int         cyc = 0;
    bit         pdone = 0, latched = 0, done = 0, aborted = 0, prev_stall = 0;
    logic [7:0] prev_d = 8'h00;
    logic [31:0] c;

    exp_q.push_back(8'hA5);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    c = cnt;
    for (int k = 0; k < N; k++) exp_q.push_back(c[TW-1-8*k -: 8]);

    while (!done && !aborted && cyc < 400) begin
      bus.valid_in = (p < pl.size());
      bus.data_in  = (p < pl.size()) ? pl[p] : 8'($urandom);
      bus.last_in  = (p == pl.size() - 1);
      case (rmode)
        0:       bus.ready_out = 1'b1;
        1:       bus.ready_out = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.ready_out = 1'($urandom_range(0, 1));
      endcase
      bus.clock_cycles_valid = pdone && !latched && (wait_cnt >= delay);
      bus.clock_cycles       = latched ? $urandom : cnt;
      #1;
      if (prev_stall) begin
        check({tag, ".stall_valid"}, bus.valid_out, 1);
        check({tag, ".stall_data"},  bus.data_out, prev_d);
      end
      check({tag, ".ready_in_gated"}, bus.ready_in & ~bus.ready_out, 0);
      check({tag, ".cc_ready"}, bus.clock_cycles_ready, pdone && !latched);
      if (pdone && !latched) check({tag, ".wait_valid"}, bus.valid_out, 0);
      if (cyc > 0) check({tag, ".busy"}, bus.busy, 1);

      if (bus.valid_out && bus.ready_out) begin
        got_d.push_back(bus.data_out);
        got_l.push_back(bus.last_out);
        if (bus.last_out) done = 1;
      end
      if (bus.valid_in && bus.ready_in) begin
        if (bus.last_in) pdone = 1;
        p++;
      end
      if (bus.clock_cycles_valid && bus.clock_cycles_ready) latched = 1;
      if (pdone && !latched) wait_cnt++;
      prev_stall = bus.valid_out && !bus.ready_out;
      prev_d     = bus.data_out;
      if (abort >= 0 && got_d.size() == 1 + pl.size() + abort) aborted = 1;
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end

    if (aborted) begin
      foreach (got_d[i]) check({tag, ".partial_byte"}, got_d[i], exp_q[i]);
      drive_idle();
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_idle({tag, ".after_reset"});
    end else begin
      if (!done) check({tag, ".frame_timeout"}, 0, 1);
      check({tag, ".frame_len"}, got_d.size(), exp_q.size());
      foreach (got_d[i]) begin
        if (i < exp_q.size()) check({tag, ".byte"}, got_d[i], exp_q[i]);
        check({tag, ".last"}, got_l[i], (i == exp_q.size() - 1));
      end
      drive_idle();
      #1;
      check_idle({tag, ".post"});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  vec_t    tbl[7];
  byte_q_t q;

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle("reset");
    @(posedge clock);
    @(negedge clock);

    //          rst   vi    ccv   ro    vo    dout   busy  ccr   rin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      reset                  = tbl[i].rst;
      bus.valid_in           = tbl[i].vi;
      bus.data_in            = 8'h3C;
      bus.last_in            = 1'b0;
      bus.clock_cycles_valid = tbl[i].ccv;
      bus.clock_cycles       = 32'h1234_5678;
      bus.ready_out          = tbl[i].ro;
      #1;
      check("tbl.valid_out", bus.valid_out, tbl[i].vo);
      check("tbl.data_out",  bus.data_out,  tbl[i].dout);
      check("tbl.busy",      bus.busy,      tbl[i].bsy);
      check("tbl.cc_ready",  bus.clock_cycles_ready, tbl[i].ccr);
      check("tbl.ready_in",  bus.ready_in,  tbl[i].rin);
      @(posedge clock);
      @(negedge clock);
    end
    drive_idle();
    @(posedge clock);
    @(negedge clock);

    q = {8'h11, 8'h22, 8'h33};
    run_frame(q, 32'h0000_012C, 0, 0, -1, "basic");
    q = {8'h7F};
    run_frame(q, 32'hDEAD_BEEF, 0, 0, -1, "single");
    q = {8'h11, 8'h22, 8'h33};
    run_frame(q, 32'h0000_012C, 1, 0, -1, "toggle");
    q = {8'h5A, 8'hC3};
    run_frame(q, 32'h0BAD_F00D, 0, 10, -1, "delayed");
    q = {8'h11, 8'h22};
    run_frame(q, 32'h1234_5678, 0, 0, 2, "abort");
    q = {8'h99};
    run_frame(q, 32'hCAFE_0001, 0, 0, -1, "after_abort");

    for (int f = 0; f < 20; f++) begin
      int len;
      q   = {};
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) q.push_back(8'($urandom));
      run_frame(q, $urandom, 2, $urandom_range(0, 5), -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/egress_scheduler.md
Name: egress_scheduler

Overview:
- Shares one byte-wide output link (e.g. UART TX FIFO) between two requesters on the processor side: the processor's egress result stream and the processor's 32-bit clock-cycle measurement.
- Sequences each run into a single framed packet on the link, in this order: header byte, result payload, cycle count (MSB first), with last marking the end of the frame.

Parameters:
- DATA_SIZE, 8, width of result beats and of output link beats.
- TIMER_SIZE, 32, width of clock-cycle count; must be an integer multiple of DATA_SIZE.
- HEADER_BYTE, 8'hA5, value emitted as the first beat of every frame.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high.
- data_in  input  DATA_SIZE  processor egress data.
- valid_in  input  1  processor egress valid.
- ready_in  output  1  processor egress ready.
- last_in  input  1  final beat of the processor result.
- clock_cycles  input  TIMER_SIZE  measured cycle count.
- clock_cycles_valid  input  1  cycle count available.
- clock_cycles_ready  output  1  cycle count accepted.
- data_out  output  DATA_SIZE  link data.
- valid_out  output  1  link valid.
- ready_out  input  1  link ready.
- last_out  output  1  final beat of the frame.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Handshake: a transfer occurs on a cycle where valid and ready are both high. valid_out, once raised, holds with stable data_out until accepted.
- Reset: state=IDLE, index=0, count shift register=0. All outputs are 0: ready_in, clock_cycles_ready, valid_out, last_out, busy, data_out.
- Definition: N = TIMER_SIZE/DATA_SIZE (4 at defaults).
- IDLE:
  - All outputs are 0.
  - valid_in=1 moves the FSM to HEADER on the next cycle.
  - No data_in beat is consumed in IDLE.
  - clock_cycles_valid in IDLE is ignored and not acknowledged.
- HEADER:
  - Drives data_out=HEADER_BYTE, valid_out=1, last_out=0, ready_in=0.
  - On ready_out=1, moves to STREAM.
- STREAM (combinational pass-through, zero latency):
  - data_out=data_in, valid_out=valid_in, ready_in=ready_out, last_out=0 (last_in is suppressed on the link).
  - A transfer with last_in=1 moves the FSM to COUNT_WAIT.
  - A single-beat result (last_in on the first beat) is legal.
- COUNT_WAIT:
  - valid_out=0, ready_in=0, clock_cycles_ready=1.
  - When clock_cycles_valid=1, the cycle count is latched into the shift register, index is cleared to 0, and the FSM moves to COUNT_SEND.
  - clock_cycles_ready is high only in this state.
- COUNT_SEND:
  - data_out = top DATA_SIZE bits of the shift register, valid_out=1, last_out=(index==N-1).
  - On ready_out=1: shift left by DATA_SIZE, index+1.
  - Accepting the beat with last_out=1 returns the FSM to IDLE.
  - The latched value is unaffected by later changes on clock_cycles.
- Back-to-back frames: a new frame may start the cycle after returning to IDLE. Minimum one idle cycle between frames.
- index width: clog2(N), minimum 1. index never wraps within a frame.
- Reset mid-frame: immediate return to IDLE. A partially sent frame is abandoned (no last_out emitted). The latched count is discarded.
- Simultaneous events:
  - In STREAM, valid_in and last_in arriving while ready_out=0 causes no transfer and no state change.
  - Changes to ready_out in HEADER or COUNT_SEND only stall; they never reorder beats.

Test Plan:
- Reset, then check outputs; raise clock_cycles_valid while IDLE -> all outputs 0 and clock_cycles_ready stays 0.
- Result stream 0x11,0x22,0x33 (last on 0x33) with count 0x0000012C, ready_out=1 -> link shows A5,11,22,33,00,00,01,2C; last_out only on 2C; busy falls the cycle after.
- Single-beat result 0x7F with count 0xDEADBEEF -> A5,7F,DE,AD,BE,EF; last_out on EF.
- ready_out toggling 1,0,0,1 throughout the frame -> identical byte sequence, no duplicates or drops, data_out stable during stalls, ready_in=0 whenever ready_out=0 in STREAM.
- clock_cycles_valid delayed 10 cycles after the last result beat -> valid_out=0 for those cycles, frame then completes correctly; changing clock_cycles after the latch does not change the emitted bytes.
- Reset asserted after the 2nd count byte -> FSM is IDLE next cycle with outputs 0; a subsequent run emits a complete new frame beginning with A5.
